window_line_buffer: RTL and testbench
=====================================

// Module: window_line_buffer
// PURPOSE
//  Parametrised sliding-window generator for the raster-scan filter pipeline. It stores KERNEL-1
//  previous video lines and emits a full KERNELxKERNEL pixel window once per accepted pixel.
//  It sits between the pixel source and the convolution/filter kernels.
//  It adds valid/SOF framing, row/col tracking, window-valid gating and EOF marking.
// PARAMETERS
//  WIDTH       320  active pixels per line (>= KERNEL)
//  HEIGHT      240  active lines per frame (>= KERNEL)
//  DATA_WIDTH  8    bits per pixel
//  KERNEL      3    window edge length; odd, 3..7
// PORTS
//  clk         in   1                          pipeline clock
//  reset       in   1                          asynchronous, active-high
//  in_valid    in   1                          pixel_in accepted this cycle (no backpressure)
//  in_sof      in   1                          qualifies in_valid: this pixel is row 0, col 0
//  pixel_in    in   DATA_WIDTH                 raster-order pixel
//  out_valid   out  1                          out_window/out_row/out_col valid this cycle
//  out_eof     out  1                          window whose bottom-right is last pixel of frame
//  out_row     out  $clog2(HEIGHT)             row of bottom-right tap
//  out_col     out  $clog2(WIDTH)              col of bottom-right tap
//  out_window  out  KERNEL*KERNEL*DATA_WIDTH   tap(r,c) at [(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-high.
//  - Reset clears col/row counters, shift registers and every output to 0.
//  - Line RAMs (KERNEL-1 banks, depth WIDTH, distributed) are not cleared.
//  - Accept = in_valid. Cycles without in_valid change no state. out_valid=0 in those cycles.
//    out_window, out_row and out_col hold their values.
//  - Line RAM bank k is addressed by col; reads return the old value and writes store the new value.
//    On accept, bank 0 receives pixel_in and bank k receives the old bank k-1 value.
//  - Row r of the window is fed by bank KERNEL-2-r for r < KERNEL-1. Row KERNEL-1 is fed by pixel_in.
//    Each row is a KERNEL-deep horizontal shift register. Tap c=KERNEL-1 is the newest column,
//    and tap (0,0) is the oldest row and column.
//  - Latency: pixel accepted in cycle N -> its window on the outputs in cycle N+1. out_valid is a
//    1-cycle pulse per qualifying accept.
//  - Counters: col increments per accept. When col==WIDTH-1, col wraps to 0 and row increments.
//    When row==HEIGHT-1 and col==WIDTH-1, both wrap to 0 automatically.
//  - in_sof with in_valid forces this pixel to row=0,col=0 (the counters then continue from there).
//    Any partial frame is discarded, and RAM contents are not cleared. in_sof without in_valid is ignored.
//  - Window valid (default): out_valid=1 only when row>=KERNEL-1 and col>=KERNEL-1. Such windows lie
//    wholly inside the frame. This gives (HEIGHT-KERNEL+1)*(WIDTH-KERNEL+1) outputs per frame.
//  - out_eof=1 with out_valid for the window at (HEIGHT-1, WIDTH-1). Otherwise out_eof=0.
//  - Async reset mid-frame: outputs drop to 0 immediately. The next frame must start with in_sof.
//    Counting restarts at 0,0 whether or not in_sof is present.
// CONFIGURATION
//  WINDOW_BORDER_VALID_EN defined:
//    - out_valid=1 on every accept (HEIGHT*WIDTH outputs per frame).
//    - Taps outside the frame (tap row index < KERNEL-1-row, or tap col index < KERNEL-1-col) are driven to 0.
//      Taps that wrap from the previous line or frame, or hold stale RAM data, are therefore never visible.
//  WINDOW_BORDER_VALID_EN undefined:
//    - The default gating above applies. Border positions produce no out_valid.
//    - out_window is unmasked raw shift-register data.
// TESTING  (WIDTH=8, HEIGHT=6, KERNEL=3, pixel = (row<<4)+col+1)
//  1 Reset asserted mid-stream -> out_valid=0, out_eof=0, out_window=0 in the same cycle; they stay 0 until an accept.
//  2 Full frame, in_sof on first pixel, in_valid=1 continuous -> exactly 24 out_valid.
//    The first is at (2,2), one cycle after the (2,2) accept, with tap(0,0)=0x01 and tap(2,2)=0x23.
//  3 Same frame with random in_valid bubbles -> identical 24 windows in order. Each arrives 1 cycle after its accept.
//    Outputs hold during bubbles.
//  4 in_sof at old-frame position (3,4), then a fresh frame -> no output until new (2,2).
//    The new (2,2) window equals test 2's (2,2) window.
//  5 Two back-to-back frames, no second in_sof -> out_eof only at (5,7) each frame.
//    The frame-2 (2,2) window contains only frame-2 pixels.
//  6 WINDOW_BORDER_VALID_EN -> 48 out_valid per frame. At (0,0) only tap(2,2)=0x01 is nonzero.
//    At (1,0) tap(1,2)=0x01 and tap(2,2)=0x11, with all other taps 0.

Source files
------------

// File: rtl/window_line_buffer.sv
// Sliding KERNELxKERNEL window generator over a raster pixel stream, backed by KERNEL-1 line RAMs.
// Define WINDOW_BORDER_VALID_EN to emit a window on every pixel with out-of-frame taps zeroed.
module window_line_buffer #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL     = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic                                 in_sof,
  input  logic [DATA_WIDTH-1:0]                pixel_in,
  output logic                                 out_valid,
  output logic                                 out_eof,
  output logic [$clog2(HEIGHT)-1:0]            out_row,
  output logic [$clog2(WIDTH)-1:0]             out_col,
  output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  out_window
);

  localparam int RW  = $clog2(HEIGHT);
  localparam int CW  = $clog2(WIDTH);
  localparam int KM1 = KERNEL - 1;

  logic [CW-1:0]         col_q, col_d, cur_col;
  logic [RW-1:0]         row_q, row_d, cur_row;
  logic                  last_col, last_row;
  logic [DATA_WIDTH-1:0] line_q [KM1][WIDTH];
  logic [DATA_WIDTH-1:0] rd [KM1];
  logic [DATA_WIDTH-1:0] win_q [KERNEL][KERNEL];
  logic [DATA_WIDTH-1:0] win_d [KERNEL][KERNEL];
  logic                  out_valid_q, out_valid_d;
  logic                  out_eof_q, out_eof_d;
  logic [RW-1:0]         out_row_q;
  logic [CW-1:0]         out_col_q;

`ifdef WINDOW_BORDER_VALID_EN
  function automatic logic tap_visible(int r, int c, logic [RW-1:0] row, logic [CW-1:0] col);
    return ((r + int'(row)) >= KM1) && ((c + int'(col)) >= KM1);
  endfunction
`endif

  // Position of the pixel on the input this cycle; in_sof pins it to the frame origin.
  always_comb begin
    cur_col  = in_sof ? '0 : col_q;
    cur_row  = in_sof ? '0 : row_q;
    last_col = (cur_col == CW'(WIDTH - 1));
    last_row = (cur_row == RW'(HEIGHT - 1));
    col_d    = col_q;
    row_d    = row_q;
    if (in_valid) begin
      col_d = last_col ? '0 : cur_col + 1'b1;
      if (last_col) row_d = last_row ? '0 : cur_row + 1'b1;
      else          row_d = cur_row;
    end
  end

  always_comb begin
    for (int k = 0; k < KM1; k++) rd[k] = line_q[k][cur_col];
  end

  // Banks form a vertical delay chain: each accept pushes the column one line deeper.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      line_q[0][cur_col] <= pixel_in;
      for (int k = 1; k < KM1; k++) line_q[k][cur_col] <= rd[k-1];
    end
  end

  always_comb begin
    for (int r = 0; r < KERNEL; r++)
      for (int c = 0; c < KERNEL; c++)
        win_d[r][c] = win_q[r][c];
    if (in_valid) begin
      for (int r = 0; r < KERNEL; r++)
        for (int c = 0; c < KM1; c++)
          win_d[r][c] = win_q[r][c+1];
      for (int r = 0; r < KM1; r++) win_d[r][KM1] = rd[KERNEL-2-r];
      win_d[KM1][KM1] = pixel_in;
    end
  end

  always_comb begin
    out_eof_d = in_valid && last_col && last_row;
`ifdef WINDOW_BORDER_VALID_EN
    out_valid_d = in_valid;
`else
    out_valid_d = in_valid && (cur_row >= RW'(KM1)) && (cur_col >= CW'(KM1));
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      for (int r = 0; r < KERNEL; r++)
        for (int c = 0; c < KERNEL; c++)
          win_q[r][c] <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_eof_q   <= out_eof_d;
      if (in_valid) begin
        out_row_q <= cur_row;
        out_col_q <= cur_col;
      end
      for (int r = 0; r < KERNEL; r++)
        for (int c = 0; c < KERNEL; c++)
          win_q[r][c] <= win_d[r][c];
    end
  end

  // The shift registers are the window; only the optional border mask sits in front.
  always_comb begin
    out_window = '0;
    for (int r = 0; r < KERNEL; r++)
      for (int c = 0; c < KERNEL; c++) begin
`ifdef WINDOW_BORDER_VALID_EN
        out_window[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] =
          tap_visible(r, c, out_row_q, out_col_q) ? win_q[r][c] : '0;
`else
        out_window[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
`endif
      end
  end

  assign out_valid = out_valid_q;
  assign out_eof   = out_eof_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// Scoreboard bench for window_line_buffer on an 8x6 frame with a 3x3 kernel.
module tb_window_line_buffer;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;
  localparam int K  = 3;
  localparam int WW = K*K*DW;
`ifdef WINDOW_BORDER_VALID_EN
  localparam bit BORDER = 1'b1;
  localparam int EXP_PER_FRAME = W*H;
`else
  localparam bit BORDER = 1'b0;
  localparam int EXP_PER_FRAME = (H-K+1)*(W-K+1);
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_sof = 1'b0;
  logic [DW-1:0]         pixel_in = '0;
  logic                  out_valid, out_eof;
  logic [$clog2(H)-1:0]  out_row;
  logic [$clog2(W)-1:0]  out_col;
  logic [WW-1:0]         out_window;

  window_line_buffer #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .KERNEL(K)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .pixel_in(pixel_in),
    .out_valid(out_valid), .out_eof(out_eof), .out_row(out_row), .out_col(out_col),
    .out_window(out_window)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          row;
    int          col;
    bit          eof;
    logic [WW-1:0] win;
    int          cyc;
  } exp_t;

  exp_t          sbq[$];
  int            vectors = 0;
  int            errors = 0;
  int            cyc = 0;
  logic          last_acc = 1'b0;
  int            out_cnt = 0;
  int            eof_cnt = 0;
  logic [WW-1:0] win22, win00, win10;
  logic [WW-1:0] prev_win = '0;
  int            prev_row = 0, prev_col = 0;

  function automatic logic [DW-1:0] pix(int f, int r, int c);
    return DW'((r << 4) + c + 1) ^ (f != 0 ? 8'h80 : 8'h00);
  endfunction

  function automatic logic [WW-1:0] calc_win(int f, int row, int col);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        int pr, pc;
        pr = row - (K-1) + r;
        pc = col - (K-1) + c;
        if (pr >= 0 && pc >= 0) w[(r*K+c)*DW +: DW] = pix(f, pr, pc);
      end
    return w;
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    last_acc <= in_valid;
  end

  // Scoreboard consumer and idle-cycle hold monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        exp_t e;
        out_cnt++;
        if (out_eof) eof_cnt++;
        if (out_row == 2 && out_col == 2) win22 = out_window;
        if (out_row == 0 && out_col == 0) win00 = out_window;
        if (out_row == 1 && out_col == 0) win10 = out_window;
        vectors++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output row=%0d col=%0d at cycle %0d", out_row, out_col, cyc);
        end else begin
          e = sbq.pop_front();
          if (out_window !== e.win || int'(out_row) != e.row || int'(out_col) != e.col ||
              out_eof !== e.eof || cyc != e.cyc + 1) begin
            errors++;
            $display("FAIL window got row=%0d col=%0d eof=%0b win=%h cyc=%0d, want row=%0d col=%0d eof=%0b win=%h cyc=%0d",
                     out_row, out_col, out_eof, out_window, cyc, e.row, e.col, e.eof, e.win, e.cyc + 1);
          end
        end
      end else begin
        vectors++;
        if (out_eof !== 1'b0) begin
          errors++;
          $display("FAIL eof_without_valid got %b want 0 at cycle %0d", out_eof, cyc);
        end
        if (sbq.size() > 0 && sbq[0].cyc + 1 <= cyc) begin
          errors++;
          $display("FAIL missing_output want row=%0d col=%0d at cycle %0d, out_valid=0", sbq[0].row, sbq[0].col, sbq[0].cyc + 1);
          void'(sbq.pop_front());
        end
        if (!last_acc) begin
          vectors++;
          if (out_window !== prev_win || int'(out_row) != prev_row || int'(out_col) != prev_col) begin
            errors++;
            $display("FAIL hold got row=%0d col=%0d win=%h want row=%0d col=%0d win=%h", out_row, out_col, out_window, prev_row, prev_col, prev_win);
          end
        end
      end
    end
    prev_win = out_window;
    prev_row = int'(out_row);
    prev_col = int'(out_col);
  end

  task automatic drive_pix(input int f, input int r, input int c, input bit sof);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    pixel_in = pix(f, r, c);
    if (BORDER || (r >= K-1 && c >= K-1))
      sbq.push_back('{row: r, col: c, eof: (r == H-1 && c == W-1), win: calc_win(f, r, c), cyc: cyc});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  task automatic drive_frame(input int f, input bit sof_first, input bit bubbles);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (bubbles && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        drive_pix(f, r, c, sof_first && r == 0 && c == 0);
      end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_eof !== 1'b0 || out_window !== '0 || out_row !== '0 || out_col !== '0) begin
      errors++;
      $display("FAIL reset_state got valid=%b eof=%b row=%0d col=%0d win=%h want all 0", out_valid, out_eof, out_row, out_col, out_window);
    end
    reset = 1'b0;
    for (int i = 0; i < 2*W + 5; i++) drive_pix(0, i / W, i % W, i == 0);
    @(negedge clk);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    sbq.delete();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_eof !== 1'b0 || out_window !== '0) begin
      errors++;
      $display("FAIL reset_async got valid=%b eof=%b win=%h want 0", out_valid, out_eof, out_window);
    end
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_eof !== 1'b0 || out_window !== '0 || out_row !== '0 || out_col !== '0) begin
        errors++;
        $display("FAIL reset_hold got valid=%b eof=%b row=%0d col=%0d win=%h want all 0", out_valid, out_eof, out_row, out_col, out_window);
      end
    end
  endtask

  task automatic check_frame_end(input string name, input int cnt0, input int nframes);
    idle(3);
    vectors++;
    if (out_cnt - cnt0 != nframes * EXP_PER_FRAME || sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_count got %0d outputs (%0d pending) want %0d", name, out_cnt - cnt0, sbq.size(), nframes * EXP_PER_FRAME);
    end
  endtask

  task automatic check_win22(input string name, input logic [DW-1:0] t00, input logic [DW-1:0] t22);
    vectors++;
    if (win22[0 +: DW] !== t00 || win22[8*DW +: DW] !== t22) begin
      errors++;
      $display("FAIL %s_win22 got tap00=%h tap22=%h want %h %h", name, win22[0 +: DW], win22[8*DW +: DW], t00, t22);
    end
  endtask

  task automatic test_full_frame;
    int c0;
    c0 = out_cnt;
    win22 = '1;
    drive_frame(0, 1'b1, 1'b0);
    check_frame_end("full_frame", c0, 1);
    check_win22("full_frame", 8'h01, 8'h23);
  endtask

  task automatic test_bubbles;
    int c0;
    c0 = out_cnt;
    win22 = '1;
    drive_frame(0, 1'b1, 1'b1);
    check_frame_end("bubbles", c0, 1);
    check_win22("bubbles", 8'h01, 8'h23);
  endtask

  task automatic test_sof_restart;
    int c0;
    for (int i = 0; i < 3*W + 4; i++) drive_pix(0, i / W, i % W, i == 0);
    idle(2);
    win22 = '1;
    c0 = out_cnt;
    drive_frame(0, 1'b1, 1'b0);
    check_frame_end("sof_restart", c0, 1);
    check_win22("sof_restart", 8'h01, 8'h23);
  endtask

  task automatic test_back_to_back;
    int c0, e0;
    c0 = out_cnt;
    e0 = eof_cnt;
    drive_frame(0, 1'b1, 1'b0);
    drive_frame(1, 1'b0, 1'b0);
    check_frame_end("back_to_back", c0, 2);
    vectors++;
    if (eof_cnt - e0 != 2) begin
      errors++;
      $display("FAIL back_to_back_eof got %0d eof pulses want 2", eof_cnt - e0);
    end
    check_win22("back_to_back", 8'h81, 8'hA3);
  endtask

  task automatic test_border;
    logic [WW-1:0] exp00, exp10;
    int c0;
    exp00 = '0;
    exp00[8*DW +: DW] = 8'h01;
    exp10 = '0;
    exp10[5*DW +: DW] = 8'h01;
    exp10[8*DW +: DW] = 8'h11;
    win00 = '1;
    win10 = '1;
    c0 = out_cnt;
    drive_frame(1, 1'b0, 1'b0);
    drive_frame(0, 1'b0, 1'b0);
    check_frame_end("border", c0, 2);
    vectors++;
    if (win00 !== exp00) begin
      errors++;
      $display("FAIL border_00 got %h want %h", win00, exp00);
    end
    vectors++;
    if (win10 !== exp10) begin
      errors++;
      $display("FAIL border_10 got %h want %h", win10, exp10);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_bubbles();
    test_sof_restart();
    test_back_to_back();
    if (BORDER) test_border();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
